// File: rtl/serial_pkg.sv
// Shared serial-link definitions: receiver/transmitter state encodings and parity modes.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    PAR   = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // acc is the XOR of all data bits and the parity bit.
  function automatic logic parity_error(input int mode, input logic acc);
    if (mode == PAR_EVEN)     return acc;
    else if (mode == PAR_ODD) return ~acc;
    else                      return 1'b0;
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out shift register; new bits enter at the MSB so an
// LSB-first stream lands in natural bit order after W shifts.
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] sh_q;

  always_ff @(posedge clk) begin
    if (clear)         sh_q <= '0;
    else if (shift_en) sh_q <= {din, sh_q[W-1:1]};
  end

  assign q = sh_q;

endmodule

// File: rtl/serial_rx.sv
// Framed serial receiver: start bit, LSB-first data, optional parity, one stop bit.
// The line is sampled only on bit_en ticks; valid is a one-clock registered pulse.
module serial_rx
  import serial_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 bit_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 shift_en;
  logic [DATA_BITS-1:0] shreg;

  sipo_shift #(.W(DATA_BITS)) u_shift (
    .clk      (clk),
    .clear    (clear),
    .shift_en (shift_en),
    .din      (rxd),
    .q        (shreg)
  );

  always_ff @(posedge clk) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      case (state_q)
        IDLE:    if (!rxd) state_d = DATA;
        DATA:    if (cnt_q == LAST) state_d = (PARITY != PAR_NONE) ? PAR : STOP;
        PAR:     state_d = STOP;
        STOP:    state_d = rxd ? IDLE : BREAK;
        BREAK:   if (rxd) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // valid defaults low so it drops the cycle after STOP regardless of tick spacing.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_d   = data_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    valid_d  = 1'b0;
    shift_en = 1'b0;
    busy     = (state_q != IDLE);
    if (bit_en) begin
      case (state_q)
        IDLE: if (!rxd) begin
          cnt_d = '0;
          acc_d = 1'b0;
        end
        DATA: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          acc_d    = acc_q ^ rxd;
        end
        PAR:  acc_d = acc_q ^ rxd;
        STOP: begin
          data_d  = shreg;
          perr_d  = parity_error(PARITY, acc_q);
          ferr_d  = ~rxd;
          valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule
